// File: rtl/tiny_rv_pkg.sv
// Shared tiny_rv definitions: opcodes, source-use struct and hazard-controller states.
// The DIV_WAIT state exists only when TINY_RV_DIV_STALL_EN is defined.
package tiny_rv_pkg;

    localparam logic [6:0] RV_LUI    = 7'b0110111;
    localparam logic [6:0] RV_AUIPC  = 7'b0010111;
    localparam logic [6:0] RV_JAL    = 7'b1101111;
    localparam logic [6:0] RV_JALR   = 7'b1100111;
    localparam logic [6:0] RV_BRANCH = 7'b1100011;
    localparam logic [6:0] RV_LOAD   = 7'b0000011;
    localparam logic [6:0] RV_STORE  = 7'b0100011;
    localparam logic [6:0] RV_OP_IMM = 7'b0010011;
    localparam logic [6:0] RV_OP     = 7'b0110011;

    typedef struct packed {
        logic rs1;
        logic rs2;
    } src_use_t;

`ifdef TINY_RV_DIV_STALL_EN
    typedef enum logic [1:0] {StRun, StMemWait, StFlush, StDivWait} hz_state_t;
`else
    typedef enum logic [1:0] {StRun, StMemWait, StFlush} hz_state_t;
`endif

endpackage

// File: rtl/tiny_rv_src_use.sv
// Combinational opcode-to-source-use decoder; also intended for the forwarding unit.
module tiny_rv_src_use
    import tiny_rv_pkg::*;
(
    input  logic [6:0] opcode,
    output src_use_t   src_use
);

    // LUI, AUIPC, JAL and unknown opcodes read no registers.
    always_comb begin
        src_use = '0;
        case (opcode)
            RV_JALR, RV_LOAD, RV_OP_IMM: begin
                src_use.rs1 = 1'b1;
            end
            RV_BRANCH, RV_STORE, RV_OP: begin
                src_use.rs1 = 1'b1;
                src_use.rs2 = 1'b1;
            end
            default: src_use = '0;
        endcase
    end

endmodule

// File: rtl/tiny_rv_hazard_ctrl.sv
// Pipeline stall/flush sequencer: load-use, memory wait and redirect refill window.
// Optional divide stall (DIV_WAIT state, ex_div_start port) under TINY_RV_DIV_STALL_EN.
module tiny_rv_hazard_ctrl
    import tiny_rv_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned DIV_CYCLES   = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [6:0]  dec_opcode,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
`ifdef TINY_RV_DIV_STALL_EN
    input  logic        ex_div_start,
`endif
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        o_fetch_stall,
    output logic        o_decode_stall,
    output logic        o_decode_flush,
    output logic        o_ex_bubble,
    output logic        o_ex_stall,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc
);

    hz_state_t  state_q, state_d;
    logic [3:0] flush_cnt_q, flush_cnt_d;
    src_use_t   src_use;
    logic       load_use;

`ifdef TINY_RV_DIV_STALL_EN
    logic [5:0] div_cnt_q, div_cnt_d;
`else
    logic unused_div_cycles;
    assign unused_div_cycles = ^DIV_CYCLES;
`endif

    tiny_rv_src_use u_src_use (
        .opcode  (dec_opcode),
        .src_use (src_use)
    );

    assign load_use = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                      ((src_use.rs1 && (ex_rd == dec_rs1)) ||
                       (src_use.rs2 && (ex_rd == dec_rs2)));

    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
`ifdef TINY_RV_DIV_STALL_EN
        div_cnt_d      = div_cnt_q;
`endif
        o_fetch_stall  = 1'b0;
        o_decode_stall = 1'b0;
        o_decode_flush = 1'b0;
        o_ex_bubble    = 1'b0;
        o_ex_stall     = 1'b0;
        o_redirect     = 1'b0;
        o_redirect_pc  = '0;

        unique case (state_q)
            StRun: begin
                if (ex_redirect) begin
                    o_redirect     = 1'b1;
                    o_redirect_pc  = ex_redirect_pc;
                    o_decode_flush = 1'b1;
                    o_ex_bubble    = 1'b1;
                    flush_cnt_d    = 4'(FLUSH_CYCLES);
                    state_d        = StFlush;
                end else if (mem_req && !mem_ack) begin
                    o_fetch_stall  = 1'b1;
                    o_decode_stall = 1'b1;
                    o_ex_stall     = 1'b1;
                    state_d        = StMemWait;
`ifdef TINY_RV_DIV_STALL_EN
                end else if (ex_div_start) begin
                    o_fetch_stall  = 1'b1;
                    o_decode_stall = 1'b1;
                    o_ex_stall     = 1'b1;
                    div_cnt_d      = 6'(DIV_CYCLES - 1);
                    state_d        = StDivWait;
`endif
                end else if (load_use) begin
                    o_fetch_stall  = 1'b1;
                    o_decode_stall = 1'b1;
                    o_ex_bubble    = 1'b1;
                end
            end
            // Execute is frozen here and keeps presenting any redirect; it is acted on in RUN.
            StMemWait: begin
                if (mem_ack) begin
                    state_d = StRun;
                end else begin
                    o_fetch_stall  = 1'b1;
                    o_decode_stall = 1'b1;
                    o_ex_stall     = 1'b1;
                end
            end
            StFlush: begin
                o_decode_flush = 1'b1;
                o_ex_bubble    = 1'b1;
                flush_cnt_d    = flush_cnt_q - 4'd1;
                if (flush_cnt_q <= 4'd1) begin
                    state_d = StRun;
                end
            end
`ifdef TINY_RV_DIV_STALL_EN
            StDivWait: begin
                if (div_cnt_q == 6'd0) begin
                    state_d = StRun;
                end else begin
                    o_fetch_stall  = 1'b1;
                    o_decode_stall = 1'b1;
                    o_ex_stall     = 1'b1;
                    div_cnt_d      = div_cnt_q - 6'd1;
                end
            end
`endif
            default: state_d = StRun;
        endcase

        // Decode stage gives flush priority over stall; mirror that here.
        if (o_decode_flush) begin
            o_decode_stall = 1'b0;
        end

        if (i_reset) begin
            o_fetch_stall  = 1'b0;
            o_decode_stall = 1'b0;
            o_decode_flush = 1'b1;
            o_ex_bubble    = 1'b0;
            o_ex_stall     = 1'b0;
            o_redirect     = 1'b0;
            o_redirect_pc  = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
`ifdef TINY_RV_DIV_STALL_EN
            div_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
`ifdef TINY_RV_DIV_STALL_EN
            div_cnt_q   <= div_cnt_d;
`endif
        end
    end

endmodule
